// File: rtl/decode_execute_core_pkg.sv
// Shared encodings for decode_execute_core: stage codes, ALU ops, MIPS opcode/funct values.
// Optional trace of register-file writes is enabled with the GRF_TRACE_EN macro.
package decode_execute_core_pkg;

  // Pipeline stage by which an operand is needed / a result is available.
  localparam logic [1:0] STG_D    = 2'd0;
  localparam logic [1:0] STG_E    = 2'd1;
  localparam logic [1:0] STG_M    = 2'd2;
  localparam logic [1:0] STG_NONE = 2'd3;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_LUI = 3'd3;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/decode_execute_core_grf.sv
// 32x32 general register file with same-cycle write-through bypass; $0 is hard-wired to zero.
// Defining GRF_TRACE_EN prints each non-reset write at the clock edge.
module decode_execute_core_grf
  import decode_execute_core_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [4:0]  i_rd_addr_a,
  input  logic [4:0]  i_rd_addr_b,
  output logic [31:0] o_rd_data_a,
  output logic [31:0] o_rd_data_b
);

  logic [31:0] r_regs [32];

  // Reset wins over a write arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'h0;
      end
    end else if (i_wb_addr != 5'd0) begin
      r_regs[i_wb_addr] <= i_wb_data;
    end
  end

`ifdef GRF_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && i_wb_addr != 5'd0) begin
      $display("%0t: $%0d <= %h", $time, i_wb_addr, i_wb_data);
    end
  end
`else
`endif

  always_comb begin
    if (i_rd_addr_a == 5'd0) begin
      o_rd_data_a = 32'h0;
    end else if (i_rd_addr_a == i_wb_addr) begin
      o_rd_data_a = i_wb_data;
    end else begin
      o_rd_data_a = r_regs[i_rd_addr_a];
    end
  end

  always_comb begin
    if (i_rd_addr_b == 5'd0) begin
      o_rd_data_b = 32'h0;
    end else if (i_rd_addr_b == i_wb_addr) begin
      o_rd_data_b = i_wb_data;
    end else begin
      o_rd_data_b = r_regs[i_rd_addr_b];
    end
  end

endmodule

// File: rtl/decode_execute_core.sv
// Register file, instruction decoder and ALU for the 5-stage MIPS pipeline (no pipeline registers here).
// GRF_TRACE_EN enables a simulation trace of register-file writes.
module decode_execute_core
  import decode_execute_core_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pc,
  output logic [4:0]  d_rs_addr,
  output logic [4:0]  d_rt_addr,
  output logic [31:0] d_rs_raw,
  output logic [31:0] d_rt_raw,
  input  logic [31:0] d_rs_val,
  input  logic [31:0] d_rt_val,
  output logic [1:0]  d_rs_stage,
  output logic [1:0]  d_rt_stage,
  output logic [4:0]  d_wr_addr,
  output logic [1:0]  d_wr_stage,
  output logic [2:0]  d_alu_op,
  output logic        d_alu_src_imm,
  output logic [31:0] d_ext_imm,
  output logic        d_mem_write,
  output logic [31:0] d_next_pc,
  output logic [31:0] d_link,
  input  logic [31:0] e_rs_val,
  input  logic [31:0] e_rt_val,
  input  logic [2:0]  e_alu_op,
  input  logic        e_alu_src_imm,
  input  logic [31:0] e_ext_imm,
  output logic [31:0] e_alu_result
);

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [4:0]  w_shamt;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [15:0] w_imm;
  logic [25:0] w_index;
  logic [31:0] w_sext_imm;
  logic [31:0] w_zext_imm;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_branch_tgt;
  logic [31:0] w_jump_tgt;
  logic [31:0] w_alu_b;
  logic        w_rtype_ok;

  assign w_opcode = d_instr[31:26];
  assign w_rs     = d_instr[25:21];
  assign w_rt     = d_instr[20:16];
  assign w_rd     = d_instr[15:11];
  assign w_shamt  = d_instr[10:6];
  assign w_funct  = d_instr[5:0];
  assign w_imm    = d_instr[15:0];
  assign w_index  = d_instr[25:0];

  assign w_sext_imm   = {{16{w_imm[15]}}, w_imm};
  assign w_zext_imm   = {16'h0, w_imm};
  assign w_pc_plus4   = d_pc + 32'd4;
  assign w_branch_tgt = d_pc + {w_sext_imm[29:0], 2'b00};
  assign w_jump_tgt   = {d_pc[31:28], w_index, 2'b00};
  // None of the supported R-type ops use a shift amount; a nonzero one is an unknown encoding.
  assign w_rtype_ok   = (w_shamt == 5'd0);
  assign d_link       = w_pc_plus4;

  // GRF is read by the raw instruction fields so the operand is available even before decode settles.
  decode_execute_core_grf u_grf (
    .clk         (clk),
    .reset       (reset),
    .i_wb_addr   (wb_addr),
    .i_wb_data   (wb_data),
    .i_rd_addr_a (w_rs),
    .i_rd_addr_b (w_rt),
    .o_rd_data_a (d_rs_raw),
    .o_rd_data_b (d_rt_raw)
  );

  always_comb begin
    d_rs_addr     = 5'd0;
    d_rt_addr     = 5'd0;
    d_rs_stage    = STG_NONE;
    d_rt_stage    = STG_NONE;
    d_wr_addr     = 5'd0;
    d_wr_stage    = STG_D;
    d_alu_op      = ALU_ADD;
    d_alu_src_imm = 1'b0;
    d_ext_imm     = w_sext_imm;
    d_mem_write   = 1'b0;
    d_next_pc     = w_pc_plus4;
    case (w_opcode)
      OP_RTYPE: begin
        if (w_rtype_ok) begin
          case (w_funct)
            FN_ADDU, FN_SUBU: begin
              d_rs_addr  = w_rs;
              d_rs_stage = STG_E;
              d_rt_addr  = w_rt;
              d_rt_stage = STG_E;
              d_wr_addr  = w_rd;
              d_wr_stage = STG_E;
              d_alu_op   = (w_funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
            end
            FN_JR: begin
              d_rs_addr  = w_rs;
              d_rs_stage = STG_D;
              d_next_pc  = d_rs_val;
            end
            default: ;
          endcase
        end
      end
      OP_ORI: begin
        d_rs_addr     = w_rs;
        d_rs_stage    = STG_E;
        d_wr_addr     = w_rt;
        d_wr_stage    = STG_E;
        d_alu_op      = ALU_OR;
        d_alu_src_imm = 1'b1;
        d_ext_imm     = w_zext_imm;
      end
      OP_LUI: begin
        d_wr_addr     = w_rt;
        d_wr_stage    = STG_E;
        d_alu_op      = ALU_LUI;
        d_alu_src_imm = 1'b1;
        d_ext_imm     = w_zext_imm;
      end
      OP_LW: begin
        d_rs_addr     = w_rs;
        d_rs_stage    = STG_E;
        d_wr_addr     = w_rt;
        d_wr_stage    = STG_M;
        d_alu_src_imm = 1'b1;
      end
      OP_SW: begin
        d_rs_addr     = w_rs;
        d_rs_stage    = STG_E;
        d_rt_addr     = w_rt;
        d_rt_stage    = STG_M;
        d_mem_write   = 1'b1;
        d_alu_src_imm = 1'b1;
      end
      OP_BEQ: begin
        d_rs_addr  = w_rs;
        d_rs_stage = STG_D;
        d_rt_addr  = w_rt;
        d_rt_stage = STG_D;
        d_next_pc  = (d_rs_val == d_rt_val) ? w_branch_tgt : w_pc_plus4;
      end
      OP_J: begin
        d_next_pc = w_jump_tgt;
      end
      OP_JAL: begin
        d_next_pc  = w_jump_tgt;
        d_wr_addr  = REG_RA;
        d_wr_stage = STG_D;
      end
      default: ;
    endcase
    // A write to $0 is no write at all, so it carries the no-write stage as well.
    if (d_wr_addr == 5'd0) begin
      d_wr_stage = STG_D;
    end
  end

  assign w_alu_b = e_alu_src_imm ? e_ext_imm : e_rt_val;

  always_comb begin
    case (e_alu_op)
      ALU_ADD: e_alu_result = e_rs_val + w_alu_b;
      ALU_SUB: e_alu_result = e_rs_val - w_alu_b;
      ALU_OR:  e_alu_result = e_rs_val | w_alu_b;
      ALU_LUI: e_alu_result = {w_alu_b[15:0], 16'h0};
      default: e_alu_result = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_decode_execute_core.sv
// Directed and randomized checks of decode_execute_core against an instruction-level reference model.
module tb_decode_execute_core;

  logic        clk;
  logic        reset;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic [4:0]  d_rs_addr, d_rt_addr;
  logic [31:0] d_rs_raw, d_rt_raw;
  logic [31:0] d_rs_val, d_rt_val;
  logic [1:0]  d_rs_stage, d_rt_stage;
  logic [4:0]  d_wr_addr;
  logic [1:0]  d_wr_stage;
  logic [2:0]  d_alu_op;
  logic        d_alu_src_imm;
  logic [31:0] d_ext_imm;
  logic        d_mem_write;
  logic [31:0] d_next_pc;
  logic [31:0] d_link;
  logic [31:0] e_rs_val, e_rt_val;
  logic [2:0]  e_alu_op;
  logic        e_alu_src_imm;
  logic [31:0] e_ext_imm;
  logic [31:0] e_alu_result;

  int total = 0;
  int bad   = 0;
  logic [31:0] model_regs [32];

  // Instruction kinds the bench can emit.
  localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4, K_SW = 5;
  localparam int K_BEQ = 6, K_J = 7, K_JAL = 8, K_JR = 9, K_NOP = 10, K_BADOP = 11, K_BADFN = 12;

  decode_execute_core dut (
    .clk(clk), .reset(reset), .wb_addr(wb_addr), .wb_data(wb_data),
    .d_instr(d_instr), .d_pc(d_pc),
    .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
    .d_rs_raw(d_rs_raw), .d_rt_raw(d_rt_raw),
    .d_rs_val(d_rs_val), .d_rt_val(d_rt_val),
    .d_rs_stage(d_rs_stage), .d_rt_stage(d_rt_stage),
    .d_wr_addr(d_wr_addr), .d_wr_stage(d_wr_stage),
    .d_alu_op(d_alu_op), .d_alu_src_imm(d_alu_src_imm), .d_ext_imm(d_ext_imm),
    .d_mem_write(d_mem_write), .d_next_pc(d_next_pc), .d_link(d_link),
    .e_rs_val(e_rs_val), .e_rt_val(e_rt_val), .e_alu_op(e_alu_op),
    .e_alu_src_imm(e_alu_src_imm), .e_ext_imm(e_ext_imm), .e_alu_result(e_alu_result)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] addu_instr(input logic [4:0] rs, input logic [4:0] rt,
                                             input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, 6'h21};
  endfunction

  // One GRF cycle: drive at negedge, check combinational reads, then let the edge commit.
  task automatic grf_cycle(input logic rst, input logic [4:0] wa, input logic [31:0] wd,
                           input logic [4:0] ra, input logic [4:0] rb);
    logic [31:0] ea, eb;
    @(negedge clk);
    reset = rst; wb_addr = wa; wb_data = wd;
    d_instr = addu_instr(ra, rb, 5'd1);
    #1;
    ea = (ra == 0) ? 32'h0 : ((ra == wa) ? wd : model_regs[ra]);
    eb = (rb == 0) ? 32'h0 : ((rb == wa) ? wd : model_regs[rb]);
    chk("grf_rs_raw", d_rs_raw, ea);
    chk("grf_rt_raw", d_rt_raw, eb);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    end else if (wa != 0) begin
      model_regs[wa] = wd;
    end
  endtask

  // Build an instruction of a given kind and compare every decode output it defines.
  task automatic run_decode(input int kind, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] idx,
                            input logic [31:0] pc, input logic [31:0] rsv, input logic [31:0] rtv);
    logic [4:0]  x_rs_a, x_rt_a, x_wr_a;
    logic [1:0]  x_rs_s, x_rt_s, x_wr_s;
    logic [31:0] x_npc, x_sext, x_zext;
    logic        x_mem, chk_alu;
    logic [2:0]  x_op;
    logic        x_src;
    logic [31:0] x_ext;
    logic [5:0]  badop;
    x_rs_a = 0; x_rt_a = 0; x_wr_a = 0;
    x_rs_s = 3; x_rt_s = 3; x_wr_s = 0;
    x_npc = pc + 4; x_mem = 0; chk_alu = 0; x_op = 0; x_src = 0; x_ext = 0;
    x_sext = 32'(signed'(imm));
    x_zext = 32'(imm);
    case (kind)
      K_ADDU, K_SUBU: begin
        d_instr = {6'h00, rs, rt, rd, 5'd0, (kind == K_ADDU) ? 6'h21 : 6'h23};
        x_rs_a = rs; x_rs_s = 1; x_rt_a = rt; x_rt_s = 1; x_wr_a = rd; x_wr_s = 1;
        chk_alu = 1; x_op = (kind == K_ADDU) ? 3'd0 : 3'd1; x_src = 0;
      end
      K_ORI: begin
        d_instr = {6'h0D, rs, rt, imm};
        x_rs_a = rs; x_rs_s = 1; x_wr_a = rt; x_wr_s = 1;
        chk_alu = 1; x_op = 2; x_src = 1; x_ext = x_zext;
      end
      K_LUI: begin
        d_instr = {6'h0F, rs, rt, imm};
        x_wr_a = rt; x_wr_s = 1; chk_alu = 1; x_op = 3; x_src = 1; x_ext = x_zext;
      end
      K_LW: begin
        d_instr = {6'h23, rs, rt, imm};
        x_rs_a = rs; x_rs_s = 1; x_wr_a = rt; x_wr_s = 2;
        chk_alu = 1; x_op = 0; x_src = 1; x_ext = x_sext;
      end
      K_SW: begin
        d_instr = {6'h2B, rs, rt, imm};
        x_rs_a = rs; x_rs_s = 1; x_rt_a = rt; x_rt_s = 2; x_mem = 1;
        chk_alu = 1; x_op = 0; x_src = 1; x_ext = x_sext;
      end
      K_BEQ: begin
        d_instr = {6'h04, rs, rt, imm};
        x_rs_a = rs; x_rs_s = 0; x_rt_a = rt; x_rt_s = 0;
        if (rsv == rtv) x_npc = pc + x_sext * 4;
      end
      K_J, K_JAL: begin
        d_instr = {(kind == K_J) ? 6'h02 : 6'h03, idx};
        x_npc = (pc & 32'hF000_0000) + 32'(idx) * 4;
        if (kind == K_JAL) begin x_wr_a = 31; x_wr_s = 0; end
      end
      K_JR: begin
        d_instr = {6'h00, rs, 15'd0, 6'h08};
        x_rs_a = rs; x_rs_s = 0; x_npc = rsv;
      end
      K_BADOP: begin
        badop = 6'h3F;
        if (rs[0]) badop = 6'h20;
        d_instr = {badop, rs, rt, imm};
      end
      K_BADFN: d_instr = {6'h00, rs, rt, rd, 5'd0, 6'h3F};
      default: d_instr = 32'h0;
    endcase
    if (x_wr_a == 0) x_wr_s = 0;
    d_pc = pc; d_rs_val = rsv; d_rt_val = rtv;
    #1;
    chk($sformatf("k%0d_rs_addr", kind), 32'(d_rs_addr), 32'(x_rs_a));
    chk($sformatf("k%0d_rt_addr", kind), 32'(d_rt_addr), 32'(x_rt_a));
    chk($sformatf("k%0d_rs_stage", kind), 32'(d_rs_stage), 32'(x_rs_s));
    chk($sformatf("k%0d_rt_stage", kind), 32'(d_rt_stage), 32'(x_rt_s));
    chk($sformatf("k%0d_wr_addr", kind), 32'(d_wr_addr), 32'(x_wr_a));
    chk($sformatf("k%0d_wr_stage", kind), 32'(d_wr_stage), 32'(x_wr_s));
    chk($sformatf("k%0d_mem_write", kind), 32'(d_mem_write), 32'(x_mem));
    chk($sformatf("k%0d_next_pc", kind), d_next_pc, x_npc);
    chk($sformatf("k%0d_link", kind), d_link, pc + 4);
    if (chk_alu) begin
      chk($sformatf("k%0d_alu_op", kind), 32'(d_alu_op), 32'(x_op));
      chk($sformatf("k%0d_alu_src", kind), 32'(d_alu_src_imm), 32'(x_src));
      if (x_src) chk($sformatf("k%0d_ext_imm", kind), d_ext_imm, x_ext);
    end
  endtask

  task automatic run_alu(input logic [2:0] op, input logic src, input logic [31:0] a,
                         input logic [31:0] b_reg, input logic [31:0] b_imm);
    logic [31:0] b, exp;
    e_alu_op = op; e_alu_src_imm = src; e_rs_val = a; e_rt_val = b_reg; e_ext_imm = b_imm;
    b = src ? b_imm : b_reg;
    case (op)
      3'd0: exp = a + b;
      3'd1: exp = a - b;
      3'd2: exp = a | b;
      3'd3: exp = b * 32'h10000;
      default: exp = 32'h0;
    endcase
    #1;
    chk($sformatf("alu_op%0d", op), e_alu_result, exp);
  endtask

  initial begin
    reset = 1; wb_addr = 0; wb_data = 0; d_instr = 0; d_pc = 0;
    d_rs_val = 0; d_rt_val = 0; e_rs_val = 0; e_rt_val = 0;
    e_alu_op = 0; e_alu_src_imm = 0; e_ext_imm = 0;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    repeat (2) @(posedge clk);

    // Reset state, bypass, write commit, reset clears, reset beats a same-cycle write.
    grf_cycle(0, 5'd0, 32'h0, 5'd5, 5'd7);
    grf_cycle(0, 5'd5, 32'h1234_5678, 5'd5, 5'd0);
    grf_cycle(0, 5'd0, 32'h0, 5'd5, 5'd5);
    grf_cycle(1, 5'd5, 32'hABCD_0000, 5'd6, 5'd7);
    grf_cycle(0, 5'd0, 32'hFFFF_FFFF, 5'd5, 5'd0);
    grf_cycle(0, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd5);

    for (int n = 0; n < 300; n++) begin
      grf_cycle(($urandom_range(0, 49) == 0), 5'($urandom_range(0, 31)), $urandom,
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    // Directed decode cases.
    @(negedge clk);
    reset = 0; wb_addr = 0;
    run_decode(K_ADDU, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h3004, 0, 0);
    run_alu(3'd0, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0);
    run_decode(K_LW, 5'd29, 5'd4, 5'd0, 16'hFFFC, 26'h0, 32'h3004, 0, 0);
    run_decode(K_SW, 5'd29, 5'd4, 5'd0, 16'h0008, 26'h0, 32'h3004, 0, 0);
    run_decode(K_BEQ, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 32'h3004, 32'h55, 32'h55);
    run_decode(K_BEQ, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 32'h3004, 32'h55, 32'h56);
    run_decode(K_JAL, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0C0, 32'h3004, 0, 0);
    run_decode(K_JR, 5'd31, 5'd0, 5'd0, 16'h0, 26'h0, 32'h3004, 32'h3008, 0);
    run_decode(K_NOP, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 32'h3004, 0, 0);
    run_decode(K_ADDU, 5'd1, 5'd2, 5'd0, 16'h0, 26'h0, 32'h3004, 0, 0);
    run_decode(K_LUI, 5'd0, 5'd9, 5'd0, 16'h8001, 26'h0, 32'h3004, 0, 0);
    run_alu(3'd3, 1'b1, 32'h1234, 32'h0, 32'h0000_8001);
    run_alu(3'd1, 1'b0, 32'h0, 32'h1, 32'h0);
    run_alu(3'd5, 1'b0, 32'hFFFF, 32'hFFFF, 32'h1);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] rsv;
      rsv = $urandom;
      run_decode($urandom_range(0, 12), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 16'($urandom), 26'($urandom), $urandom & 32'hFFFF_FFFC,
                 rsv, ($urandom_range(0, 1) == 0) ? rsv : $urandom);
      run_alu(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_execute_core.md
Name: decode_execute_core

Overview:
- Register file, instruction decoder and ALU for the 5-stage MIPS pipeline, packaged as one block.
- Sits between the fetch stage and the memory stage. Pipeline registers, hazard/stall logic and operand forwarding muxes stay in the enclosing top level.
- Decoder outputs register addresses, per-operand "needed-by" stage and result "ready-at" stage, so the top level can stall or forward.
- Supported ISA: addu, subu, ori, lui, lw, sw, beq, j, jal, jr, nop. Branches have one delay slot.

Parameters:
- none. Fixed 32-bit datapath, 32 registers.

Ports:
- clk  in  1  clock; GRF write edge.
- reset  in  1  synchronous, active-high; clears the GRF.
- wb_addr  in  5  GRF write address; 0 means no write.
- wb_data  in  32  GRF write data.
- d_instr  in  32  instruction in decode.
- d_pc  in  32  current fetch PC (= decode instruction PC + 4, i.e. the delay slot).
- d_rs_addr, d_rt_addr  out  5  source register addresses; 0 when the operand is unused.
- d_rs_raw, d_rt_raw  out  32  GRF read data with write-through bypass.
- d_rs_val, d_rt_val  in  32  forwarded decode operands, used for beq/jr.
- d_rs_stage, d_rt_stage  out  2  stage by which the operand is required.
- d_wr_addr  out  5  destination register; 0 means no write.
- d_wr_stage  out  2  stage at which the result is produced.
- d_alu_op  out  3  ALU operation.
- d_alu_src_imm  out  1  ALU B operand: 1 = immediate, 0 = rt.
- d_ext_imm  out  32  extended immediate.
- d_mem_write  out  1  store.
- d_next_pc  out  32  next fetch PC.
- d_link  out  32  d_pc+4, the jal return value.
- e_rs_val, e_rt_val  in  32  forwarded execute operands.
- e_alu_op  in  3  latched ALU operation.
- e_alu_src_imm  in  1  latched ALU B select.
- e_ext_imm  in  32  latched extended immediate.
- e_alu_result  out  32  ALU result.

Behaviour:
- Stage codes: D=0, E=1, M=2, NONE=3.
- ALU ops: ADD=0, SUB=1, OR=2, LUI=3. Other codes yield 0.
- GRF:
  - 32x32 registers; writes on posedge clk when wb_addr!=0.
  - reset clears all registers on that edge; reset has priority over a write in the same cycle.
  - Reads are combinational. $0 always reads 0.
  - If a read address equals wb_addr and is nonzero, the read returns wb_data in the same cycle.
- Decode per instruction (opcode/funct):
  - addu (0/21h), subu (0/23h): rs=E, rt=E; wr=rd at E; op ADD/SUB; src reg.
  - ori (0Dh): rs=E; wr=rt at E; op OR; imm zero-extended.
  - lui (0Fh): no reads; wr=rt at E; op LUI; imm zero-extended.
  - lw (23h): rs=E; wr=rt at M; op ADD; imm sign-extended.
  - sw (2Bh): rs=E, rt=M; no write; mem_write=1; op ADD; imm sign-extended.
  - beq (04h): rs=D, rt=D. If d_rs_val==d_rt_val then next_pc = d_pc + (sext(imm)<<2), else d_pc+4.
  - j (02h): next_pc = {d_pc[31:28], index, 2'b00}.
  - jal (03h): same target as j; wr=31 at D.
  - jr (0/08h): rs=D; next_pc = d_rs_val.
- Defaults for every instruction unless stated above:
  - unused operand: addr 0, stage NONE.
  - no write: d_wr_addr 0, d_wr_stage D.
  - next_pc = d_pc+4.
  - mem_write 0.
- Unknown encodings and all-zero instructions behave as nop. A write to rd/rt = 0 is reported as addr 0.
- ALU:
  - A = e_rs_val; B = e_alu_src_imm ? e_ext_imm : e_rt_val.
  - Arithmetic wraps modulo 2^32; no overflow traps.
  - LUI result = B<<16.
- All decode and ALU outputs are purely combinational, zero latency. The GRF is the only state.

Optional Feature:
- Macro GRF_TRACE_EN.
- Defined: every non-reset GRF write (wb_addr!=0) prints "<time>: $<addr> <= <data hex>" at the clock edge.
- Undefined: no simulation output, identical logic.

Decomposition:
- Shared package/header holds the stage codes, ALU op codes, and opcode/funct constants, which the top level also uses.
- One natural sub-module: decode_execute_grf, the register file with bypass. Decoder and ALU stay inline.

Test Plan:
- Reset, then write $5=12345678h with wb_addr=5; read $5 in the same cycle -> d_rs_raw=12345678h (bypass). Assert reset -> $5 reads 0 on the next cycle.
- wb_addr=0, wb_data=FFFFFFFFh -> $0 still reads 0.
- addu $3,$1,$2 -> rs=1, rt=2 at E, wr=3 at E, op ADD. With e_rs=FFFFFFFFh, e_rt=1 -> result 0.
- lw $4,-4($29) -> wr=4 at M, ext_imm=FFFFFFFCh, op ADD. sw $4,8($29) -> rt stage M, mem_write=1, d_wr_addr=0.
- beq at PC 3000h (d_pc=3004h), imm=FFFFh, equal operands -> next_pc=3000h; unequal -> 3008h.
- jal 0C0h from d_pc=3004h -> next_pc=300h, wr=31 at D, d_link=3008h. jr with d_rs_val=3008h -> next_pc=3008h, rs stage D.
